// File: rtl/pix_stream_pkg.sv
// Shared constants and FSM state encoding for the pixel stream framer.
package pix_stream_pkg;

   localparam int DWIDTH_DEF   = 16;
   localparam int PIX_BITS_DEF = 10;
   localparam int PIX_MAX      = 1023;
   localparam int COL_NUM_DEF  = 2448;
   localparam int ROW_NUM_DEF  = 2048;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } framer_state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream buffer: output register plus one skid register.
// Latency: 1 cycle accept -> dst_vld. Backpressure: parent stops accepting while skid is occupied.
// Backpressure: the ready toward the source is a parent-owned flop fed from skid_free_nxt.
module axis_skid_buf #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         src_vld,
   input  logic         src_rdy,
   input  logic [W-1:0] src_dat,
   output logic         dst_vld,
   input  logic         dst_rdy,
   output logic [W-1:0] dst_dat,
   output logic         skid_free_nxt,
   output logic         empty_nxt
);

   logic         skid_vld;
   logic [W-1:0] skid_dat;
   logic         src_fire;
   logic         dst_load;

   assign src_fire = src_vld & src_rdy;
   assign dst_load = !dst_vld || dst_rdy;

   // src_rdy is only high while the skid is empty, so a skid drain never races an accept.
   assign skid_free_nxt = dst_load || !(skid_vld || src_fire);
   assign empty_nxt     = skid_free_nxt && !(dst_load ? (skid_vld || src_fire) : 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dst_vld  <= 1'b0;
         dst_dat  <= '0;
         skid_vld <= 1'b0;
         skid_dat <= '0;
      end else if (dst_load) begin
         if (skid_vld) begin
            dst_vld  <= 1'b1;
            dst_dat  <= skid_dat;
            skid_vld <= 1'b0;
         end else begin
            dst_vld <= src_fire;
            if (src_fire) dst_dat <= src_dat;
         end
      end else if (src_fire) begin
         skid_vld <= 1'b1;
         skid_dat <= src_dat;
      end
   end

endmodule

// File: rtl/pix_stream_framer.sv
// Clamps signed pixels to PIX_BITS and tags SOF/EOL per frame; FRAMER_SAT_CNT_EN adds sat_cnt.
// Latency: 1 cycle input accept -> output valid, 1 pixel/cycle with downstream ready.
// Backpressure: output + skid buffer; input ready drops (registered) while the skid is full.
module pix_stream_framer
   import pix_stream_pkg::*;
#(
   parameter int DWIDTH   = DWIDTH_DEF,
   parameter int PIX_BITS = PIX_BITS_DEF,
   parameter int COL_NUM  = COL_NUM_DEF,
   parameter int ROW_NUM  = ROW_NUM_DEF
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              new_frame,
   input  logic [DWIDTH-1:0] input_r_TDATA,
   input  logic              input_r_TVALID,
   output logic              input_r_TREADY,
   output logic [DWIDTH-1:0] output_r_TDATA,
   output logic              output_r_TVALID,
   input  logic              output_r_TREADY,
   output logic              output_r_TUSER,
   output logic              output_r_TLAST,
   output logic              frame_done,
   output logic              busy
`ifdef FRAMER_SAT_CNT_EN
  ,output logic [31:0]       sat_cnt
`endif
);

   localparam int COL_W   = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
   localparam int ROW_W   = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
   localparam int PIX_LIM = (1 << PIX_BITS) - 1;
   localparam logic [DWIDTH-1:0] LIM_W    = DWIDTH'(PIX_LIM);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COL_NUM - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROW_NUM - 1);

   framer_state_t     state;
   logic [COL_W-1:0]  col_cnt;
   logic [ROW_W-1:0]  row_cnt;
   logic              in_fire;
   logic              is_neg;
   logic              is_over;
   logic              clamped;
   logic [DWIDTH-1:0] pix_clamped;
   logic              tag_sof;
   logic              tag_eol;
   logic              frame_last;
   logic              skid_free_nxt;
   logic              buf_empty_nxt;
   logic [DWIDTH+1:0] buf_in_dat;
   logic [DWIDTH+1:0] buf_out_dat;

   assign in_fire = input_r_TVALID && input_r_TREADY;

   // Input is two's complement; anything above the pixel ceiling saturates.
   assign is_neg      = input_r_TDATA[DWIDTH-1];
   assign is_over     = !is_neg && (input_r_TDATA > LIM_W);
   assign clamped     = is_neg || is_over;
   assign pix_clamped = is_neg ? '0 : (is_over ? LIM_W : input_r_TDATA);

   assign tag_sof    = (row_cnt == '0) && (col_cnt == '0);
   assign tag_eol    = (col_cnt == COL_LAST);
   assign frame_last = tag_eol && (row_cnt == ROW_LAST);
   assign buf_in_dat = {tag_sof, tag_eol, pix_clamped};

   axis_skid_buf #(.W(DWIDTH + 2)) u_skid (
      .clk           (ap_clk),
      .rst_n         (ap_rst_n),
      .src_vld       (input_r_TVALID),
      .src_rdy       (input_r_TREADY),
      .src_dat       (buf_in_dat),
      .dst_vld       (output_r_TVALID),
      .dst_rdy       (output_r_TREADY),
      .dst_dat       (buf_out_dat),
      .skid_free_nxt (skid_free_nxt),
      .empty_nxt     (buf_empty_nxt)
   );

   assign output_r_TDATA = buf_out_dat[DWIDTH-1:0];
   assign output_r_TLAST = buf_out_dat[DWIDTH];
   assign output_r_TUSER = buf_out_dat[DWIDTH+1];

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state          <= IDLE;
         col_cnt        <= '0;
         row_cnt        <= '0;
         input_r_TREADY <= 1'b0;
         frame_done     <= 1'b0;
         busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (new_frame) begin
                  state          <= RUN;
                  busy           <= 1'b1;
                  input_r_TREADY <= 1'b1;
               end
            end
            RUN: begin
               input_r_TREADY <= skid_free_nxt;
               if (in_fire) begin
                  if (frame_last) begin
                     state          <= DRAIN;
                     input_r_TREADY <= 1'b0;
                     col_cnt        <= '0;
                     row_cnt        <= '0;
                  end else if (tag_eol) begin
                     col_cnt <= '0;
                     row_cnt <= row_cnt + 1'b1;
                  end else begin
                     col_cnt <= col_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (buf_empty_nxt) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            DONE: begin
               state      <= IDLE;
               frame_done <= 1'b0;
            end
            default: begin
               state          <= IDLE;
               input_r_TREADY <= 1'b0;
               busy           <= 1'b0;
               frame_done     <= 1'b0;
            end
         endcase
      end
   end

`ifdef FRAMER_SAT_CNT_EN
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         sat_cnt <= '0;
      end else if (state == IDLE && new_frame) begin
         sat_cnt <= '0;
      end else if (in_fire && clamped && sat_cnt != 32'hFFFF_FFFF) begin
         sat_cnt <= sat_cnt + 32'd1;
      end
   end
`else
   logic unused_clamped;
   assign unused_clamped = clamped;
`endif

endmodule

// File: tb/tb_pix_stream_framer.sv
// Scoreboard bench for pix_stream_framer with a 4x3 frame geometry.
module tb_pix_stream_framer;

   localparam int DW = 16;
   localparam int CN = 4;
   localparam int RN = 3;

   logic          ap_clk;
   logic          ap_rst_n;
   logic          new_frame;
   logic [DW-1:0] input_r_TDATA;
   logic          input_r_TVALID;
   logic          input_r_TREADY;
   logic [DW-1:0] output_r_TDATA;
   logic          output_r_TVALID;
   logic          output_r_TREADY;
   logic          output_r_TUSER;
   logic          output_r_TLAST;
   logic          frame_done;
   logic          busy;
`ifdef FRAMER_SAT_CNT_EN
   logic [31:0]   sat_cnt;
`endif

   pix_stream_framer #(.DWIDTH(DW), .PIX_BITS(10), .COL_NUM(CN), .ROW_NUM(RN)) dut (
      .ap_clk          (ap_clk),
      .ap_rst_n        (ap_rst_n),
      .new_frame       (new_frame),
      .input_r_TDATA   (input_r_TDATA),
      .input_r_TVALID  (input_r_TVALID),
      .input_r_TREADY  (input_r_TREADY),
      .output_r_TDATA  (output_r_TDATA),
      .output_r_TVALID (output_r_TVALID),
      .output_r_TREADY (output_r_TREADY),
      .output_r_TUSER  (output_r_TUSER),
      .output_r_TLAST  (output_r_TLAST),
      .frame_done      (frame_done),
      .busy            (busy)
`ifdef FRAMER_SAT_CNT_EN
     ,.sat_cnt         (sat_cnt)
`endif
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic          u;
      logic          l;
   } exp_t;

   exp_t  exp_q[$];
   time   t_q[$];
   int    errors = 0;
   int    checks = 0;
   bit    lat_chk = 0;
   bit    occ_chk = 0;
   bit    tog_en = 0;
   int    full_seen = 0;
   time   last_pop_t = 0;
   bit    prev_stall = 0;
   exp_t  held;

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Output ready toggles every cycle while tog_en is set.
   initial begin
      forever begin
         @(posedge ap_clk);
         #1;
         if (tog_en) output_r_TREADY = ~output_r_TREADY;
      end
   end

   // Monitor: queue size at a negedge equals the DUT's buffer occupancy.
   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         prev_stall = 0;
      end else begin
         if (occ_chk) begin
            chk("tready_vs_occupancy", input_r_TREADY, (exp_q.size() < 2));
            if (exp_q.size() == 2) full_seen++;
         end
         if (prev_stall) begin
            chk("hold_valid", output_r_TVALID, 1);
            chk("hold_data", output_r_TDATA, held.d);
            chk("hold_tags", {output_r_TUSER, output_r_TLAST}, {held.u, held.l});
         end
         prev_stall = output_r_TVALID && !output_r_TREADY;
         held = '{d: output_r_TDATA, u: output_r_TUSER, l: output_r_TLAST};
         if (output_r_TVALID && output_r_TREADY) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %0h expected none", output_r_TDATA);
            end else begin
               exp_t e;
               time  t;
               e = exp_q.pop_front();
               t = t_q.pop_front();
               chk("out_data", output_r_TDATA, e.d);
               chk("out_tuser", output_r_TUSER, e.u);
               chk("out_tlast", output_r_TLAST, e.l);
               if (lat_chk) chk("latency", 32'($time - t), 5);
               last_pop_t = $time;
            end
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] ed, input logic eu, input logic el);
      input_r_TVALID = 1'b1;
      input_r_TDATA  = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge ap_clk);
         if (input_r_TREADY) break;
      end
      if (!input_r_TREADY) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got tready 0 expected 1");
         input_r_TVALID = 1'b0;
         return;
      end
      @(posedge ap_clk);
      exp_q.push_back('{d: ed, u: eu, l: el});
      t_q.push_back($time);
      #1;
      input_r_TVALID = 1'b0;
   endtask

   task automatic start_frame();
      new_frame = 1'b1;
      @(posedge ap_clk);
      #1;
      new_frame = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 50; i++) begin
         @(negedge ap_clk);
         if (frame_done) break;
      end
      chk("frame_done_seen", frame_done, 1);
      if (frame_done) chk("frame_done_time", 32'($time - last_pop_t), 10);
      chk("busy_at_done", busy, 0);
      @(negedge ap_clk);
      chk("frame_done_pulse", frame_done, 0);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic send_frame(input int base);
      for (int i = 0; i < CN * RN; i++)
         send(DW'(base + i), DW'(base + i), (i == 0), ((i % CN) == CN - 1));
   endtask

   logic [DW-1:0] clamp_in  [12] = '{16'hFFFF, 16'h0400, 16'h03FF, 16'h01F4, 16'h0001, 16'h0002,
                                     16'h03FE, 16'h0100, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
   logic [DW-1:0] clamp_exp [12] = '{16'h0000, 16'h03FF, 16'h03FF, 16'h01F4, 16'h0001, 16'h0002,
                                     16'h03FE, 16'h0100, 16'h0005, 16'h0006, 16'h0007, 16'h0008};

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ap_rst_n        = 1'b0;
      new_frame       = 1'b0;
      input_r_TDATA   = '0;
      input_r_TVALID  = 1'b0;
      output_r_TREADY = 1'b1;
      repeat (3) @(posedge ap_clk);
      #1;
      chk("rst_tready", input_r_TREADY, 0);
      chk("rst_tvalid", output_r_TVALID, 0);
      chk("rst_tdata", output_r_TDATA, 0);
      chk("rst_tuser", output_r_TUSER, 0);
      chk("rst_tlast", output_r_TLAST, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;

      // Back-to-back frame with downstream always ready.
      start_frame();
      chk("run_busy", busy, 1);
      chk("run_tready", input_r_TREADY, 1);
      lat_chk = 1;
      occ_chk = 1;
      send_frame(0);
      occ_chk = 0;
      chk("drain_tready", input_r_TREADY, 0);
      chk("drain_busy", busy, 1);
      wait_done();
      lat_chk = 0;

      // Clamp vectors.
      start_frame();
      for (int i = 0; i < 12; i++)
         send(clamp_in[i], clamp_exp[i], (i == 0), ((i % CN) == CN - 1));
      wait_done();
`ifdef FRAMER_SAT_CNT_EN
      chk("sat_cnt", sat_cnt, 2);
`endif

      // Downstream ready toggling; skid must fill without loss or duplication.
      start_frame();
      occ_chk = 1;
      full_seen = 0;
      tog_en = 1;
      send_frame(16'h20);
      occ_chk = 0;
      wait_done();
      tog_en = 0;
      output_r_TREADY = 1'b1;
      chk("skid_filled", (full_seen > 0), 1);

      // Input offered in IDLE is refused; new_frame during RUN is ignored.
      input_r_TVALID = 1'b1;
      input_r_TDATA  = 16'd77;
      for (int i = 0; i < 4; i++) begin
         @(negedge ap_clk);
         chk("idle_tready", input_r_TREADY, 0);
      end
      @(posedge ap_clk);
      #1;
      input_r_TVALID = 1'b0;
      start_frame();
      for (int i = 0; i < 5; i++) send(DW'(50 + i), DW'(50 + i), (i == 0), ((i % CN) == CN - 1));
      start_frame();
      for (int i = 5; i < 12; i++) send(DW'(50 + i), DW'(50 + i), 1'b0, ((i % CN) == CN - 1));
      wait_done();

      // Reset mid-frame discards buffered data.
      start_frame();
      for (int i = 0; i < 6; i++) send(DW'(40 + i), DW'(40 + i), (i == 0), ((i % CN) == CN - 1));
      ap_rst_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", output_r_TVALID, 0);
      chk("mid_rst_tdata", output_r_TDATA, 0);
      chk("mid_rst_tags", {output_r_TUSER, output_r_TLAST}, 0);
      chk("mid_rst_tready", input_r_TREADY, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_frame_done", frame_done, 0);
`ifdef FRAMER_SAT_CNT_EN
      chk("mid_rst_sat_cnt", sat_cnt, 0);
`endif
      exp_q.delete();
      t_q.delete();
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      start_frame();
      send_frame(100);
      wait_done();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pix_stream_framer.md
PIX_STREAM_FRAMER -- requirements
Module: pix_stream_framer

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, stream data width.
REQ-002 SHALL have parameter PIX_BITS, default 10, valid pixel bits; max code 1023.
REQ-003 SHALL have parameter COL_NUM, default 2448, pixels per row.
REQ-004 SHALL have parameter ROW_NUM, default 2048, rows per frame.
REQ-005 ap_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-007 new_frame  in  1  single-cycle pulse that arms one frame.
REQ-008 input_r_TDATA  in  DWIDTH  filtered pixel from conv2d_3x3, two's-complement.
REQ-009 input_r_TVALID  in  1  upstream valid.
REQ-010 input_r_TREADY  out  1  ready to upstream.
REQ-011 output_r_TDATA  out  DWIDTH  clamped pixel, zero-extended.
REQ-012 output_r_TVALID, output_r_TREADY  out, in  1 each  downstream handshake.
REQ-013 output_r_TUSER  out  1  start of frame, high on pixel (row 0, col 0) only.
REQ-014 output_r_TLAST  out  1  end of line, high on col COL_NUM-1 of every row.
REQ-015 frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted downstream.
REQ-016 busy  out  1  high in states RUN and DRAIN.

Function
REQ-017 SHALL implement FSM IDLE -> RUN on new_frame; RUN -> DRAIN when input pixel (ROW_NUM-1, COL_NUM-1) is accepted; DRAIN -> DONE when the output holds no data; DONE -> IDLE after exactly one cycle.
REQ-018 input_r_TREADY SHALL be low in IDLE, DRAIN and DONE; in RUN it SHALL be a registered signal, high iff skid register is empty.
REQ-019 Transfer SHALL occur when TVALID and TREADY are both high in the same cycle; output data and TUSER/TLAST SHALL be held stable while output_r_TVALID is high and output_r_TREADY is low.
REQ-020 Latency input accept -> output_r_TVALID SHALL be 1 cycle with output_r_TREADY held high; throughput 1 pixel/cycle.
REQ-021 Two-entry buffering (output + skid register) SHALL guarantee no pixel is lost or duplicated under any output_r_TREADY pattern.
REQ-022 Clamp: input < 0 -> 0; input > 1023 -> 1023; else unchanged; result zero-extended to DWIDTH.
REQ-023 Column counter SHALL wrap COL_NUM-1 -> 0 and increment row; the row counter SHALL reset to 0 at frame end; tags computed from counters at input accept.
REQ-024 new_frame while not in IDLE SHALL be ignored; new_frame in DONE SHALL be ignored.
REQ-025 frame_done SHALL be high only in DONE.

Reset
REQ-026 On ap_rst_n low: state IDLE; counters 0; buffers empty; input_r_TREADY, output_r_TVALID, TUSER, TLAST, frame_done, busy all 0; output_r_TDATA 0.
REQ-027 Reset mid-frame SHALL discard buffered pixels; after release the block SHALL wait for a new new_frame.

Configuration
REQ-028 With FRAMER_SAT_CNT_EN defined: output port sat_cnt (32 bits) SHALL count clamped pixels per frame, cleared on IDLE->RUN, saturating at 2^32-1, held after frame end.
REQ-029 Without FRAMER_SAT_CNT_EN: no sat_cnt port or counter; all other behaviour identical.

Structure
REQ-030 Package pix_stream_pkg SHALL hold PIX_MAX (1023), default geometry constants, and the FSM state enum (IDLE, RUN, DRAIN, DONE).
REQ-031 Buffering SHALL be sub-module axis_skid_buf (data + TUSER + TLAST payload).

Verification (bench params COL_NUM=4, ROW_NUM=3)
REQ-032 Reset, new_frame, 12 pixels 0..11 back-to-back, ready high -> outputs 0..11 one cycle later, TUSER on 0, TLAST on 3/7/11, frame_done one cycle after 11 accepted.
REQ-033 Inputs 0xFFFF (-1), 1024, 1023, 500 -> outputs 0, 1023, 1023, 500; sat_cnt=2 when FRAMER_SAT_CNT_EN defined.
REQ-034 output_r_TREADY toggled 1-0-1-0 with continuous input valid -> sequence 0..11 intact, no duplicates, input_r_TREADY low while skid full.
REQ-035 Input before new_frame -> input_r_TREADY stays 0, no output; new_frame during RUN -> frame geometry unchanged.
REQ-036 ap_rst_n low after 6 pixels -> all outputs 0 immediately; next frame starts TUSER at its first pixel with col/row counters at 0.
